matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Streaming front/back end for the combinational N x N matrix multiplier. Accepts 27-bit
//  elements one per handshake, assembles flattened operands A then B, drives them to the
//  multiplier, waits a fixed settle time, captures the flattened product, then streams the
//  N*N result elements back out. Sits between the memory/load path and the multiplier array.
// PARAMETERS
//  N        4   matrix dimension; element count NN = N*N
//  EW       27  element width (27-bit float, treated as opaque bits; no arithmetic here)
//  MUL_LAT  2   cycles to wait for the multiplier output to settle; legal range >= 1
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input element valid
//  in_ready   out  1        input element accepted when in_valid & in_ready
//  in_data    in   EW       input element
//  mat_a      out  EW*NN    flattened A to the multiplier; element k at [EW*k +: EW]
//  mat_b      out  EW*NN    flattened B, same layout
//  mat_out    in   EW*NN    flattened product from the multiplier, same layout
//  out_valid  out  1        result element valid
//  out_ready  in   1        result element taken when out_valid & out_ready
//  out_data   out  EW       result element
//  out_last   out  1        high with the final element (k = NN-1) of a result
//  busy       out  1        high whenever state != LOAD_A or element counter != 0
// BEHAVIOUR
//  - Element order on both streams: row-major, k = i*N + j, k = 0 first.
//  - States: LOAD_A -> LOAD_B -> WAIT -> DRAIN -> LOAD_A. One element counter cnt,
//    width $clog2(NN), plus wait counter wcnt, width $clog2(MUL_LAT+1).
//  - LOAD_A / LOAD_B: in_ready = 1. On handshake, write in_data into element cnt of A or B.
//    cnt increments. At cnt = NN-1: cnt <= 0, advance to the next state.
//  - WAIT: in_ready = 0 and out_valid = 0. wcnt counts 0 .. MUL_LAT-1.
//    On the edge where wcnt = MUL_LAT-1:
//    * mat_out is registered into the result register;
//    * wcnt <= 0; state <= DRAIN.
//    The first out_valid is therefore high exactly MUL_LAT cycles after the edge that
//    accepted the last B element.
//  - DRAIN: out_valid = 1, out_data = result[cnt], out_last = (cnt == NN-1), in_ready = 0.
//    On handshake cnt increments. After the last handshake: cnt <= 0, state <= LOAD_A.
//    out_valid drops on the next cycle, so there are no bubbles-then-duplicates.
//    out_data is held stable while out_valid & !out_ready.
//  - in_data presented outside LOAD_A/LOAD_B is ignored (in_ready = 0). No element is
//    dropped or duplicated under any valid/ready pattern.
//  - mat_a and mat_b are registers. They hold their contents after WAIT, and are
//    overwritten element by element on the next load. They are not cleared between jobs.
//  - The result register is written only on the WAIT -> DRAIN edge. Changes on mat_out
//    at any other time have no effect.
//  - Reset (async assert, sync release):
//    * state = LOAD_A; cnt = 0; wcnt = 0;
//    * mat_a = 0; mat_b = 0; result = 0;
//    * out_valid = 0; out_data = 0; out_last = 0; in_ready = 1; busy = 0.
//    Reset in any state aborts the job. Partial A/B contents are cleared, and no
//    further out_valid occurs until a full new job is loaded.
// TESTING
//  Bench uses a stub multiplier where mat_out = mat_a ^ mat_b (bitwise), N = 4, MUL_LAT = 2.
//  1. Stream A = k+1 and B = 0 for k = 0..15, with in_valid held high and out_ready = 1
//     -> A accepted in 16 cycles, B accepted in 16 cycles; out_valid rises 2 cycles after
//     the last B; out_data = 1..16 on consecutive cycles; out_last only with 16.
//  2. A = 27'h7FFFFFF in all elements, B = k -> out_data = 27'h7FFFFFF ^ k;
//     verifies full width with no truncation at bit 26.
//  3. Random in_valid and out_ready gaps (50%) -> same 16 results in order;
//     out_data stable while stalled; busy = 1 from the first A handshake to the last
//     out handshake.
//  4. in_valid = 1 during WAIT and DRAIN with in_data = 27'h1234 -> in_ready = 0 and no
//     change to mat_a or mat_b; the next job loads its first element into k = 0.
//  5. Assert rst_n = 0 after 7 B elements, then release and run job 1
//     -> mat_a and mat_b read 0 during reset; result matches job 1 exactly.
//  6. Two back-to-back jobs -> the second job's A is accepted on the cycle after
//     out_last is handshaken; both result streams are correct.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Streaming loader/unloader around a combinational N x N matrix multiplier:
// collects A then B element by element, waits for the array to settle, then streams the product.
module matmul_sequencer #(
  parameter int N       = 4,
  parameter int EW      = 27,
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EW-1:0]       in_data,
  output logic [EW*N*N-1:0]   mat_a,
  output logic [EW*N*N-1:0]   mat_b,
  input  logic [EW*N*N-1:0]   mat_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EW-1:0]       out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam int WW = $clog2(MUL_LAT + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NN - 1);
  localparam logic [WW-1:0] WCNT_ZERO = WW'(0);
  localparam logic [WW-1:0] WCNT_ONE  = WW'(1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    LOAD_A   = 2'd0,
    LOAD_B   = 2'd1,
    WAIT_MUL = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [WW-1:0]       wcnt_r;
  logic [EW*NN-1:0]    result_r;

  logic                in_fire_s;
  logic                out_fire_s;
  logic [CW-1:0]       cnt_inc_s;
  logic                cnt_at_last_s;

  // Element k of a flattened row-major matrix.
  function automatic logic [EW-1:0] elem(input logic [EW*NN-1:0] vec, input logic [CW-1:0] k);
    return vec[EW*int'(k) +: EW];
  endfunction

  assign in_fire_s     = in_valid & in_ready;
  assign out_fire_s    = out_valid & out_ready;
  assign cnt_inc_s     = cnt_r + CNT_ONE;
  assign cnt_at_last_s = (cnt_r == CNT_LAST);

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= LOAD_A;
      cnt_r     <= CNT_ZERO;
      wcnt_r    <= WCNT_ZERO;
      mat_a     <= '0;
      mat_b     <= '0;
      result_r  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        LOAD_A: begin
          if (in_fire_s) begin
            mat_a[EW*int'(cnt_r) +: EW] <= in_data;
            busy <= 1'b1;
            if (cnt_at_last_s) begin
              cnt_r   <= CNT_ZERO;
              state_r <= LOAD_B;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        LOAD_B: begin
          if (in_fire_s) begin
            mat_b[EW*int'(cnt_r) +: EW] <= in_data;
            if (cnt_at_last_s) begin
              cnt_r    <= CNT_ZERO;
              wcnt_r   <= WCNT_ZERO;
              in_ready <= 1'b0;
              state_r  <= WAIT_MUL;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        WAIT_MUL: begin
          // The product is sampled once, on the final settle cycle, and never again.
          if (wcnt_r == WCNT_LAST) begin
            result_r  <= mat_out;
            wcnt_r    <= WCNT_ZERO;
            out_valid <= 1'b1;
            out_data  <= elem(mat_out, CNT_ZERO);
            out_last  <= (CNT_ZERO == CNT_LAST);
            state_r   <= DRAIN;
          end else begin
            wcnt_r <= wcnt_r + WCNT_ONE;
          end
        end
        DRAIN: begin
          if (out_fire_s) begin
            if (cnt_at_last_s) begin
              cnt_r     <= CNT_ZERO;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state_r   <= LOAD_A;
            end else begin
              cnt_r    <= cnt_inc_s;
              out_data <= elem(result_r, cnt_inc_s);
              out_last <= (cnt_inc_s == CNT_LAST);
            end
          end
        end
        default: begin
          state_r   <= LOAD_A;
          cnt_r     <= CNT_ZERO;
          wcnt_r    <= WCNT_ZERO;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer with an XOR stub multiplier; a job-level model predicts
// handshakes, operand registers and the result stream every cycle.
module tb_matmul_sequencer;

  localparam int N       = 4;
  localparam int EW      = 27;
  localparam int MUL_LAT = 2;
  localparam int NN      = N * N;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [EW-1:0]       in_data = '0;
  logic [EW*NN-1:0]    mat_a;
  logic [EW*NN-1:0]    mat_b;
  logic [EW*NN-1:0]    mat_out;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [EW-1:0]       out_data;
  logic                out_last;
  logic                busy;

  int checks = 0;
  int errors = 0;

  matmul_sequencer #(.N(N), .EW(EW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat_a(mat_a), .mat_b(mat_b), .mat_out(mat_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  // Stub multiplier.
  assign mat_out = mat_a ^ mat_b;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW*NN-1:0] act, input logic [EW*NN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [EW-1:0] m_a [NN];
  logic [EW-1:0] m_b [NN];
  logic [EW-1:0] m_res [NN];
  int  m_loaded, m_wait, m_drained;
  bit  m_waiting, m_drain;
  int  cyc, lastb_cyc;
  bit  prev_stall, prev_valid;
  logic [EW-1:0] prev_data;
  logic [EW-1:0] obs [$];

  function automatic logic [EW*NN-1:0] pack(input logic [EW-1:0] v [NN]);
    logic [EW*NN-1:0] r;
    for (int k = 0; k < NN; k++) r[EW*k +: EW] = v[k];
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < NN; k++) begin m_a[k] = '0; m_b[k] = '0; end
      m_loaded = 0; m_wait = 0; m_drained = 0; m_waiting = 0; m_drain = 0;
      prev_stall = 0; prev_valid = 0;
      chk("rst_mat_a", mat_a, '0);
      chk("rst_mat_b", mat_b, '0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end else begin
      chk("in_ready", in_ready, m_loaded < 2*NN);
      chk("out_valid", out_valid, m_drain);
      chk("out_last", out_last, m_drain && (m_drained == NN-1));
      chk("busy", busy, m_loaded != 0);
      chk("mat_a", mat_a, pack(m_a));
      chk("mat_b", mat_b, pack(m_b));
      if (m_drain) chk("out_data", out_data, m_res[m_drained]);
      if (prev_stall) chk("stall_hold", out_data, prev_data);
      // First valid result is MUL_LAT edges after the last-B edge, seen one negedge later.
      if (out_valid && !prev_valid) chk("latency", cyc - lastb_cyc, MUL_LAT + 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_valid = out_valid;

      if (in_valid && m_loaded < 2*NN) begin
        if (m_loaded < NN) m_a[m_loaded] = in_data;
        else               m_b[m_loaded-NN] = in_data;
        m_loaded++;
        if (m_loaded == 2*NN) begin
          m_waiting = 1; m_wait = 0; lastb_cyc = cyc;
        end
      end else if (m_waiting) begin
        m_wait++;
        if (m_wait == MUL_LAT) begin
          for (int k = 0; k < NN; k++) m_res[k] = m_a[k] ^ m_b[k];
          m_waiting = 0; m_drain = 1; m_drained = 0;
        end
      end else if (m_drain && out_ready) begin
        obs.push_back(out_data);
        m_drained++;
        if (m_drained == NN) begin
          m_drain = 0; m_loaded = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [EW-1:0] sa [NN];
  logic [EW-1:0] sb [NN];

  task automatic run_job(input int vprob, input int rprob, input bit extra, input int max_in);
    int  idx, outs;
    bit  acc_in, acc_out, done;
    idx = 0; outs = 0; done = 0;
    obs.delete();
    for (int g = 0; g < 3000 && !done; g++) begin
      if (idx < 2*NN) begin
        in_valid = ($urandom_range(99) < vprob);
        in_data  = (idx < NN) ? sa[idx] : sb[idx-NN];
      end else begin
        in_valid = extra;
        in_data  = 27'h0001234;
      end
      out_ready = ($urandom_range(99) < rprob);
      @(negedge clk);
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (acc_in)  idx++;
      if (acc_out) outs++;
      if ((max_in < 2*NN && idx >= max_in) || outs == NN) done = 1;
    end
    in_valid = 1'b0;
    if (!done) chk("job_timeout", 1'b0, 1'b1);
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NN; k++) begin
      sa[k] = EW'($urandom);
      sb[k] = EW'($urandom);
    end
  endtask

  task automatic job1_ops();
    for (int k = 0; k < NN; k++) begin
      sa[k] = EW'(k + 1);
      sb[k] = '0;
    end
  endtask

  initial begin
    cyc = 0; lastb_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: A = k+1, B = 0, no gaps
    job1_ops();
    run_job(100, 100, 0, 2*NN);
    chk("t1_count", obs.size(), NN);
    if (obs.size() == NN) begin
      chk("t1_first", obs[0], 27'd1);
      chk("t1_last", obs[NN-1], 27'd16);
    end

    // 2: full-width A
    for (int k = 0; k < NN; k++) begin sa[k] = 27'h7FFFFFF; sb[k] = EW'(k); end
    run_job(100, 100, 0, 2*NN);
    if (obs.size() == NN) begin
      chk("t2_elem3", obs[3], 27'h7FFFFFC);
      chk("t2_elem15", obs[15], 27'h7FFFFF0);
    end

    // 3: random gaps on both sides
    for (int j = 0; j < 3; j++) begin
      rand_ops();
      run_job(50, 50, 0, 2*NN);
      chk("t3_count", obs.size(), NN);
    end

    // 4: input offered during WAIT and DRAIN, then a fresh job
    rand_ops();
    run_job(100, 60, 1, 2*NN);
    rand_ops();
    run_job(70, 100, 0, 2*NN);

    // 5: reset after 7 B elements, then job 1
    rand_ops();
    run_job(100, 100, 0, NN + 7);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    job1_ops();
    run_job(100, 100, 0, 2*NN);
    if (obs.size() == NN) chk("t5_last", obs[NN-1], 27'd16);

    // 6: back-to-back jobs
    for (int j = 0; j < 4; j++) begin
      rand_ops();
      run_job(100, (j < 2) ? 100 : 50, 0, 2*NN);
      chk("t6_count", obs.size(), NN);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
